// File: rtl/noc_link_rx_buffer_pkg.sv
// Shared types for the NoC link receive buffer.
// Flit layout, framing states and sizing helper.
package noc_link_rx_buffer_pkg;

  localparam int FLIT_W = 64;
  localparam int DEST_W = 4;

  typedef struct packed {
    logic [FLIT_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic              is_tail;
  } flit_t;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } frame_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/noc_link_rx_buffer_if.sv
// Consumer-side valid/ready flit stream.
// master drives the flit, slave returns ready.
interface noc_link_rx_buffer_if #(
  parameter int FLIT_WIDTH = 64,
  parameter int DEST_WIDTH = 4
);
  logic                  out_valid;
  logic                  out_ready;
  logic [FLIT_WIDTH-1:0] out_data;
  logic [DEST_WIDTH-1:0] out_dest;
  logic                  out_is_tail;

  modport master (
    output out_valid,
    output out_data,
    output out_dest,
    output out_is_tail,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_dest,
    input  out_is_tail,
    output out_ready
  );
endinterface

// File: rtl/noc_link_rx_buffer_fifo.sv
// Count-based flit FIFO, DEPTH entries (power of 2).
// Caller never pushes into a full FIFO unless popping.
module noc_link_rx_buffer_fifo
  import noc_link_rx_buffer_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  flit_t         wdata,
  output flit_t         rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  flit_t         mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign rdata = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/noc_link_rx_buffer.sv
// Receive buffer for one NoC link: credit return,
// framing checks and delivered-packet counter.
module noc_link_rx_buffer
  import noc_link_rx_buffer_pkg::*;
#(
  parameter  int FLIT_WIDTH = FLIT_W,
  parameter  int DEST_WIDTH = DEST_W,
  parameter  int DEPTH      = 8,
  parameter  int CNT_WIDTH  = 16,
  localparam int OW         = clog2(DEPTH) + 1
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  noc_link_rx_buffer_if.master  out,
  output logic [OW-1:0]         occupancy,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  overflow_err,
  output logic                  dest_err
);

  flit_t                 wflit;
  flit_t                 head;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;
  frame_t                state;
  frame_t                state_nxt;
  logic [DEST_WIDTH-1:0] pkt_dest;
  logic [DEST_WIDTH-1:0] pkt_dest_nxt;
  logic                  mismatch;

  assign wflit = '{data: data_in, dest: dest_in, is_tail: is_tail_in};

  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign pop  = !empty && out.out_ready;
  assign push = send_in && (!full || pop);
  assign drop = send_in && full && !pop;

  noc_link_rx_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_noc),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wflit),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (occupancy)
  );

  assign out.out_valid   = !empty;
  assign out.out_data    = head.data;
  assign out.out_dest    = head.dest;
  assign out.out_is_tail = head.is_tail;

  always_comb begin
    state_nxt    = state;
    pkt_dest_nxt = pkt_dest;
    mismatch     = 1'b0;
    if (push) begin
      unique case (state)
        HEAD: begin
          pkt_dest_nxt = dest_in;
          if (!is_tail_in) state_nxt = BODY;
        end
        BODY: begin
          mismatch = (dest_in != pkt_dest);
          if (is_tail_in) state_nxt = HEAD;
        end
        default: state_nxt = HEAD;
      endcase
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HEAD;
      pkt_dest     <= '0;
      credit_out   <= 1'b0;
      pkt_count    <= '0;
      overflow_err <= 1'b0;
      dest_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pkt_dest   <= pkt_dest_nxt;
      credit_out <= pop;
      if (pop && head.is_tail) pkt_count <= pkt_count + CNT_WIDTH'(1);
      if (drop) overflow_err <= 1'b1;
      if (mismatch) dest_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_link_rx_buffer.sv
// Bench for noc_link_rx_buffer: vector table, corner
// sequences and a queue scoreboard with credit tracking.
module tb_noc_link_rx_buffer;

  localparam int FW = 64;
  localparam int DW = 4;
  localparam int DEPTH = 8;
  localparam int CW = 16;
  localparam int EW = FW + DW + 1;

  logic          clk_noc = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] data_in = '0;
  logic [DW-1:0] dest_in = '0;
  logic          is_tail_in = 1'b0;
  logic          send_in = 1'b0;
  logic          credit_out;
  logic [3:0]    occupancy;
  logic [CW-1:0] pkt_count;
  logic          overflow_err;
  logic          dest_err;

  noc_link_rx_buffer_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) bus ();

  noc_link_rx_buffer #(
    .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk_noc      (clk_noc),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .dest_in      (dest_in),
    .is_tail_in   (is_tail_in),
    .send_in      (send_in),
    .credit_out   (credit_out),
    .out          (bus),
    .occupancy    (occupancy),
    .pkt_count    (pkt_count),
    .overflow_err (overflow_err),
    .dest_err     (dest_err)
  );

  always #5 clk_noc = ~clk_noc;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // reference model, advanced on the falling edge
  logic [EW-1:0] q[$];
  int            m_occ = 0;
  bit            m_ovf = 0;
  bit            m_derr = 0;
  bit            m_body = 0;
  logic [DW-1:0] m_dest = '0;
  int            m_pkt = 0;
  bit            m_credit = 0;
  int            pops = 0;
  int            credits = 0;

  always @(negedge clk_noc) begin
    bit pop;
    bit push;
    if (!rst_n) begin
      q.delete();
      m_occ = 0; m_ovf = 0; m_derr = 0; m_body = 0;
      m_dest = '0; m_pkt = 0; m_credit = 0;
      pops = 0; credits = 0;
    end else begin
      chk("valid", bus.out_valid, m_occ != 0);
      chk("occ", occupancy, m_occ);
      chk("credit", credit_out, m_credit);
      chk("pkt_count", pkt_count, m_pkt[CW-1:0]);
      chk("overflow", overflow_err, m_ovf);
      chk("dest_err", dest_err, m_derr);
      if (credit_out) credits++;
      pop = (m_occ != 0) && bus.out_ready;
      if (pop) begin
        chk("flit", {bus.out_data, bus.out_dest, bus.out_is_tail}, q[0]);
        if (q[0][0]) m_pkt++;
        void'(q.pop_front());
        pops++;
      end
      push = send_in && (m_occ < DEPTH || pop);
      if (send_in && !push) m_ovf = 1;
      if (push) begin
        q.push_back({data_in, dest_in, is_tail_in});
        if (!m_body) begin
          m_dest = dest_in;
          m_body = !is_tail_in;
        end else begin
          if (dest_in != m_dest) m_derr = 1;
          if (is_tail_in) m_body = 0;
        end
      end
      m_occ = m_occ + int'(push) - int'(pop);
      m_credit = pop;
    end
  end

  typedef struct {
    bit         send;
    bit         ready;
    logic [3:0] dest;
    bit         tail;
    int         occ;
    bit         credit;
    bit         ovf;
    int         pkt;
  } vec_t;

  vec_t vt[19];

  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    send_in = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk("rst_occ", occupancy, 0);
    chk("rst_credit", credit_out, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_derr", dest_err, 0);
    chk("rst_data", bus.out_data, 0);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [FW-1:0] d, input logic [DW-1:0] ds,
                      input bit t);
    data_in = d;
    dest_in = ds;
    is_tail_in = t;
    send_in = 1'b1;
    step();
    send_in = 1'b0;
  endtask

  task automatic drain(input string nm);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && occupancy != 0; k++) step();
    chk(nm, occupancy, 0);
    step();
  endtask

  initial begin
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      vt[i] = '{1, 0, 4'd1, i == 7, i + 1, 0, 0, 0};
    vt[8] = '{1, 0, 4'd1, 1, 8, 0, 1, 0};
    vt[9] = '{1, 1, 4'd2, 1, 8, 1, 1, 0};
    for (int i = 10; i < 18; i++)
      vt[i] = '{0, 1, 4'd0, 0, 17 - i, 1, 1, (i == 16) ? 1 : (i == 17) ? 2 : 0};
    vt[18] = '{0, 1, 4'd0, 0, 0, 0, 1, 2};

    repeat (2) step();
    do_reset();

    for (int i = 0; i < 19; i++) begin
      data_in = 64'hD0D0_0000_0000_0000 | 64'(i);
      dest_in = vt[i].dest;
      is_tail_in = vt[i].tail;
      send_in = vt[i].send;
      bus.out_ready = vt[i].ready;
      step();
      chk($sformatf("v%0d_occ", i), occupancy, vt[i].occ);
      chk($sformatf("v%0d_credit", i), credit_out, vt[i].credit);
      chk($sformatf("v%0d_ovf", i), overflow_err, vt[i].ovf);
      chk($sformatf("v%0d_pkt", i), pkt_count, vt[i].pkt);
    end
    send_in = 1'b0;
    chk("drained_q", q.size(), 0);

    do_reset();
    bus.out_ready = 1'b1;
    send(64'h5000_0001, 4'd5, 0);
    send(64'h5000_0002, 4'd5, 0);
    send(64'h5000_0003, 4'd5, 1);
    send(64'h2000_0001, 4'd2, 1);
    drain("pkt_drain");
    chk("pkt_two", pkt_count, 2);
    chk("pkt_derr", dest_err, 0);

    send(64'h3000_0001, 4'd3, 0);
    send(64'h4000_0002, 4'd4, 1);
    drain("derr_drain");
    chk("derr_set", dest_err, 1);
    chk("derr_pkt", pkt_count, 3);
    repeat (5) step();
    chk("derr_sticky", dest_err, 1);

    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1);
    repeat (20) step();
    chk("hold_occ", occupancy, DEPTH);
    chk("hold_credits", credits, 0);
    for (int c = 0; c < 200; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      data_in = {$urandom, $urandom};
      dest_in = 4'($urandom_range(0, 15));
      is_tail_in = 1'($urandom_range(0, 1));
      send_in = ($urandom_range(0, 2) == 0);
      step();
    end
    send_in = 1'b0;
    drain("rand_drain");
    step();
    chk("rand_q_empty", q.size(), 0);
    chk("credits_eq_pops", credits, pops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
